// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo_ctrl block: last-operation state codes and the
// width of the occupancy counter.
package fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    NO_OP    = 3'b101,
    WR_RD    = 3'b110
  } state_t;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit more than a pointer.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer bundle of the FIFO: requests and data in, registered data,
// occupancy, flags, handshakes and last-operation state out.
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  import fifo_ctrl_pkg::*;

  localparam int CW = count_width(ADDR_WIDTH);

  // Requests are sampled on every rising edge. wr_ack/wr_err and rd_ack/rd_err
  // are one-cycle pulses reporting whether the request of the previous edge was
  // accepted or rejected; dout is valid in the same cycle that rd_ack is high.
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic [CW-1:0]         data_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [2:0]            state;

  modport master (
    output wr_en, rd_en, din,
    input  dout, data_count, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, state
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, data_count, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, state
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register file with one write port and one
// registered read port. The array itself is never reset; only the read register is.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Holds its value unless a read is accepted.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy counter, status flags and
// registered per-operation handshakes around a fifo_mem register file.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  state_t                state_q;
  logic                  wr_ack_q;
  logic                  wr_err_q;
  logic                  rd_ack_q;
  logic                  rd_err_q;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;
  logic                  hs_enable;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // With both requests, a full FIFO still reads and an empty one still writes.
  assign do_wr = bus.wr_en & ~full  & ~reset;
  assign do_rd = bus.rd_en & ~empty & ~reset;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_wr),
    .waddr (tail),
    .wdata (bus.din),
    .re    (do_rd),
    .raddr (head),
    .rdata (bus.dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      state_q  <= INIT;
    end else begin
      wr_ack_q <= do_wr;
      rd_ack_q <= do_rd;
      wr_err_q <= bus.wr_en & full;
      rd_err_q <= bus.rd_en & empty;
      if (do_wr) tail <= tail + ADDR_WIDTH'(1);
      if (do_rd) head <= head + ADDR_WIDTH'(1);
      case ({do_wr, do_rd})
        2'b11: state_q <= WR_RD;
        2'b10: begin
          state_q <= WRITE;
          count   <= count + CW'(1);
        end
        2'b01: begin
          state_q <= READ;
          count   <= count - CW'(1);
        end
        default: begin
          if (bus.wr_en)      state_q <= WR_ERROR;
          else if (bus.rd_en) state_q <= RD_ERROR;
          else                state_q <= NO_OP;
        end
      endcase
    end
  end

  // Code 111 is never produced; should it ever appear, handshakes stay quiet.
  assign hs_enable = (bus.state != 3'b111);

  assign bus.state        = state_q;
  assign bus.data_count   = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count <= CW'(AE_LEVEL));
  assign bus.wr_ack       = wr_ack_q & hs_enable;
  assign bus.wr_err       = wr_err_q & hs_enable;
  assign bus.rd_ack       = rd_ack_q & hs_enable;
  assign bus.rd_err       = rd_err_q & hs_enable;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based reference model predicts each
// cycle's status and read data; a monitor process compares against the DUT.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
  localparam int AF    = 6;
  localparam int AE    = 2;

  typedef struct {
    int         cnt;
    bit         wa, we, ra, re;
    state_t     st;
    logic [DW-1:0] dout;
  } exp_t;

  logic clk;
  logic reset;

  fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] model_q[$];   // reference FIFO contents
  logic [DW-1:0] exp_q[$];     // expected read data, popped on rd_ack
  exp_t          stat_q[$];    // expected per-cycle status
  logic [DW-1:0] last_dout;
  int            vectors;
  int            miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d);
    exp_t e;
    int   n;
    @(negedge clk);
    reset      = 1'b0;
    bus.wr_en  = wr;
    bus.rd_en  = rd;
    bus.din    = d;
    n    = model_q.size();
    e.wa = wr && (n < DEPTH);
    e.we = wr && (n == DEPTH);
    e.ra = rd && (n > 0);
    e.re = rd && (n == 0);
    if (e.ra) begin
      last_dout = model_q.pop_front();
      exp_q.push_back(last_dout);
    end
    if (e.wa) model_q.push_back(d);
    if (!wr && !rd)       e.st = NO_OP;
    else if (e.wa && e.ra) e.st = WR_RD;
    else if (e.wa)        e.st = WRITE;
    else if (e.ra)        e.st = READ;
    else if (e.we)        e.st = WR_ERROR;
    else                  e.st = RD_ERROR;
    e.cnt  = model_q.size();
    e.dout = last_dout;
    stat_q.push_back(e);
  endtask

  task automatic do_reset(input bit wr);
    exp_t e;
    @(negedge clk);
    reset     = 1'b1;
    bus.wr_en = wr;
    bus.rd_en = 1'b0;
    bus.din   = DW'($urandom);
    model_q.delete();
    last_dout = '0;
    e.cnt  = 0;
    e.wa   = 1'b0;
    e.we   = 1'b0;
    e.ra   = 1'b0;
    e.re   = 1'b0;
    e.st   = INIT;
    e.dout = '0;
    stat_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (stat_q.size() > 0) begin
      mon_e = stat_q.pop_front();
      check("data_count",   32'(bus.data_count),   32'(mon_e.cnt));
      check("full",         32'(bus.full),         32'(mon_e.cnt == DEPTH));
      check("empty",        32'(bus.empty),        32'(mon_e.cnt == 0));
      check("almost_full",  32'(bus.almost_full),  32'(mon_e.cnt >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(mon_e.cnt <= AE));
      check("wr_ack",       32'(bus.wr_ack),       32'(mon_e.wa));
      check("wr_err",       32'(bus.wr_err),       32'(mon_e.we));
      check("rd_ack",       32'(bus.rd_ack),       32'(mon_e.ra));
      check("rd_err",       32'(bus.rd_err),       32'(mon_e.re));
      check("state",        32'(bus.state),        32'(mon_e.st));
      check("dout_hold",    32'(bus.dout),         32'(mon_e.dout));
      if (bus.rd_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL read_data: rd_ack with dout 0x%0h but no read expected", bus.dout);
        end else begin
          check("read_data", 32'(bus.dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    last_dout   = '0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.din     = '0;
    repeat (2) @(posedge clk);

    // reset then idle
    do_reset(1'b0);
    repeat (3) step(1'b0, 1'b0, '0);

    // fill 0x11..0x88, then overflow attempt
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i * 32'h11));
    step(1'b1, 1'b0, DW'(32'h99));

    // drain, then underflow attempt
    repeat (9) step(1'b0, 1'b1, '0);

    // pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom));
    repeat (5) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(32'hA0 + i));
    repeat (8) step(1'b0, 1'b1, '0);

    // simultaneous read+write at mid, empty and full
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, DW'($urandom));
    repeat (3) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, DW'(32'hE0));
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, DW'(32'hF0));

    // reset mid-burst with a write pending
    repeat (7) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom));
    do_reset(1'b1);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, DW'(32'h5A5A_0001));
    step(1'b0, 1'b1, '0);

    // randomized traffic, biased toward filling then toward draining
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < bias),
             1'($urandom_range(0, 99) < (100 - bias)),
             DW'($urandom));
      end
    end
    step(1'b0, 1'b0, '0);

    repeat (2) @(negedge clk);
    check("status_queue_drained", 32'(stat_q.size()), 32'd0);
    check("read_queue_drained",   32'(exp_q.size()),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
